hazard_scoreboard: RTL

Parametrised forwarding and load-use stall controller for the pipelined datapath, replacing fixed EX/MEM forwarding comparators with a DEPTH-entry destination scoreboard. It sits beside the decode stage. Each cycle it checks the decoding instruction's source registers against in-flight writers and produces a stall request. It also produces registered forward selects that are consumed by the EX-stage operand muxes on the following cycle. Producer readiness is per-entry: ALU results forward after one stage, load results after LD_READY stages.

---
 rtl/hazard_scoreboard.sv | 116 +++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Decode-side load-use stall and EX forward-select controller built on a DEPTH-slot destination scoreboard.
// Optional HAZARD_STATS_EN macro adds saturating stall/forward counters; otherwise they read 0.
module hazard_scoreboard #(
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned RADDR_W  = 5,
  parameter int unsigned LD_READY = 2,
  parameter int unsigned FWD_W    = $clog2(DEPTH + 1)
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               id_valid,
  input  logic [RADDR_W-1:0] id_rs,
  input  logic [RADDR_W-1:0] id_rt,
  input  logic               id_uses_rs,
  input  logic               id_uses_rt,
  input  logic               id_regwrite,
  input  logic [RADDR_W-1:0] id_wsel,
  input  logic               id_is_load,
  input  logic               flush,
  input  logic               mem_wait,
  output logic               stall,
  output logic [FWD_W-1:0]   fwd_a,
  output logic [FWD_W-1:0]   fwd_b,
  output logic [31:0]        stall_count,
  output logic [31:0]        fwd_count
);

  localparam int unsigned CNT_W = 32;

  logic               r_valid [1:DEPTH];
  logic [RADDR_W-1:0] r_wsel  [1:DEPTH];
  logic [FWD_W-1:0]   r_age   [1:DEPTH];

  logic               w_found_a, w_found_b;
  logic               w_haz_a, w_haz_b;
  logic [FWD_W-1:0]   w_sel_a, w_sel_b;
  logic               w_bubble;

  // Youngest matching writer decides: stall while its result is not yet ready, else forward from it
  always_comb begin
    w_found_a = 1'b0;
    w_found_b = 1'b0;
    w_haz_a   = 1'b0;
    w_haz_b   = 1'b0;
    w_sel_a   = '0;
    w_sel_b   = '0;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      if (!w_found_a && id_uses_rs && (id_rs != '0) && r_valid[k] && (r_wsel[k] == id_rs)) begin
        w_found_a = 1'b1;
        if (FWD_W'(k) < r_age[k])
          w_haz_a = 1'b1;
        else if (k < DEPTH)
          w_sel_a = FWD_W'(k);
      end
      if (!w_found_b && id_uses_rt && (id_rt != '0) && r_valid[k] && (r_wsel[k] == id_rt)) begin
        w_found_b = 1'b1;
        if (FWD_W'(k) < r_age[k])
          w_haz_b = 1'b1;
        else if (k < DEPTH)
          w_sel_b = FWD_W'(k);
      end
    end
  end

  assign stall    = id_valid & ~flush & (w_haz_a | w_haz_b);
  assign w_bubble = stall | flush | ~id_valid;

  // Scoreboard shift and registered forward selects; mem_wait freezes everything
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned k = 1; k <= DEPTH; k++) begin
        r_valid[k] <= 1'b0;
        r_wsel[k]  <= '0;
        r_age[k]   <= '0;
      end
      fwd_a <= '0;
      fwd_b <= '0;
    end else if (!mem_wait) begin
      for (int unsigned k = DEPTH; k >= 2; k--) begin
        r_valid[k] <= r_valid[k-1];
        r_wsel[k]  <= r_wsel[k-1];
        r_age[k]   <= r_age[k-1];
      end
      r_valid[1] <= ~w_bubble & id_regwrite & (id_wsel != '0);
      r_wsel[1]  <= id_wsel;
      r_age[1]   <= id_is_load ? FWD_W'(LD_READY) : FWD_W'(1);
      fwd_a      <= w_bubble ? '0 : w_sel_a;
      fwd_b      <= w_bubble ? '0 : w_sel_b;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_fwd_count;

  // Saturating event counters, advanced only on non-frozen cycles
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stall_count <= '0;
      r_fwd_count   <= '0;
    end else if (!mem_wait) begin
      if (stall && (r_stall_count != '1))
        r_stall_count <= r_stall_count + CNT_W'(1);
      if (!w_bubble && ((w_sel_a != '0) || (w_sel_b != '0)) && (r_fwd_count != '1))
        r_fwd_count <= r_fwd_count + CNT_W'(1);
    end
  end

  assign stall_count = r_stall_count;
  assign fwd_count   = r_fwd_count;
`else
  assign stall_count = CNT_W'(0);
  assign fwd_count   = CNT_W'(0);
`endif

endmodule
